flit_tx: RTL
============

FLIT_TX -- requirements
Module: flit_tx

Interface
REQ-001 Parameter CREDITS, default 8: initial and maximum downstream buffer credits.
REQ-002 Parameter FLIT_W, default `DATA_SIZE (18): flit width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 tx_en  in  1  enables starting new flit fetches; in-flight flit always completes.
REQ-006 q_empty  in  1  source queue empty flag.
REQ-007 q_data  in  FLIT_W  source queue registered output, valid the cycle after a read strobe.
REQ-008 q_read  out  1  source queue read strobe, registered.
REQ-009 q_en  out  1  source queue enable, registered, equal to q_read.
REQ-010 tx_valid  out  1  downstream flit valid, one-cycle pulse per flit.
REQ-011 tx_flit  out  FLIT_W  downstream flit, held between pulses.
REQ-012 credit_in  in  1  one-cycle pulse returning one downstream credit.
REQ-013 credits  out  4  current credit count.
REQ-014 flit_cnt  out  16  flits sent, wraps at 16'hFFFF -> 0.
REQ-015 pkt_err  out  1  sticky packet-framing error.
REQ-016 credit_err  out  1  sticky credit-overflow error.

Function
REQ-017 Flit type SHALL be tx bits [17:16]: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 HEAD_TAIL.
REQ-018 FSM states SHALL be IDLE, READ, LOAD, SEND.
REQ-019 IDLE -> READ when tx_en=1, q_empty=0, and credits>0; otherwise stay IDLE.
REQ-020 In READ, q_read=q_en=1 for exactly one cycle; one credit is reserved (decremented) on entry.
REQ-021 READ -> LOAD unconditionally; in LOAD, q_data is captured into tx_flit at the end of the cycle.
REQ-022 LOAD -> SEND unconditionally; tx_valid=1 only in SEND, and flit_cnt increments on SEND entry.
REQ-023 SEND -> READ if the IDLE start condition holds, else SEND -> IDLE; throughput is therefore 1 flit per 3 cycles.
REQ-024 Credit update per cycle: +1 on credit_in, -1 on READ entry; both in the same cycle leaves credits unchanged.
REQ-025 credit_in with credits==CREDITS and no simultaneous reservation SHALL leave credits at CREDITS and set credit_err.
REQ-026 Credits SHALL never underflow; no READ is entered with credits==0.
REQ-027 in_pkt flag: set by HEAD, cleared by TAIL, unchanged by BODY and HEAD_TAIL, evaluated on the captured flit in LOAD.
REQ-028 pkt_err SHALL set on HEAD or HEAD_TAIL with in_pkt=1, or BODY or TAIL with in_pkt=0; the flit is still sent.
REQ-029 tx_en deasserting mid-flit SHALL NOT abort READ, LOAD, or SEND; the block returns to IDLE after SEND.
REQ-030 q_empty SHALL be sampled only in IDLE and SEND.

Reset
REQ-031 On rst=0, asynchronously: state=IDLE, q_read=0, q_en=0, tx_valid=0, tx_flit=0, credits=CREDITS, flit_cnt=0, in_pkt=0, pkt_err=0, credit_err=0.
REQ-032 Reset asserted mid-flit SHALL discard the flit (no tx_valid) and restore full credits.
REQ-033 Sticky errors SHALL clear only by reset.

Structure
REQ-034 Flit type encodings, the FSM state enum, and DATA_SIZE SHALL reside in the shared define/package file.
REQ-035 The credit counter SHALL be a sub-module credit_counter (inc, dec, count, overflow); all other logic SHALL be inline.

Verification
REQ-036 Reset, then queue holds 1 HEAD_TAIL 18'h3_0001, tx_en=1 -> q_read in cycle 1, tx_valid in cycle 3 with tx_flit=18'h3_0001, credits=7, flit_cnt=1.
REQ-037 10 flits queued, no credit_in -> exactly 8 tx_valid pulses, then credits=0, FSM in IDLE, q_read=0.
REQ-038 credits=0, then a credit_in pulse -> READ entered the next cycle and one more flit sent.
REQ-039 credit_in coincident with READ entry at credits=5 -> credits stays 5; credit_in at credits=8 while idle -> credit_err=1.
REQ-040 BODY sent with in_pkt=0 -> pkt_err=1 and the flit is still sent; HEAD, BODY, TAIL sequence -> pkt_err stays 0.
REQ-041 rst=0 asserted in LOAD -> no tx_valid, credits=8, all outputs at their reset values immediately.

Source files
------------

// File: rtl/flit_tx_pkg.sv
// Shared definitions for the flit transmitter: flit width, flit type encodings, FSM states.
package flit_tx_pkg;

    localparam int unsigned DATA_SIZE = 18;

    typedef enum logic [1:0] {
        FlitBody     = 2'b00,
        FlitTail     = 2'b01,
        FlitHead     = 2'b10,
        FlitHeadTail = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StLoad,
        StSend
    } state_e;

    // True for flit types that are only legal outside a packet.
    function automatic logic opens_pkt(flit_type_e t);
        return (t == FlitHead) || (t == FlitHeadTail);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating downstream credit counter; overflow pulses when a return would exceed MAX.
module credit_counter #(
    parameter int unsigned MAX = 8,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         overflow
);

    localparam logic [W-1:0] MaxCount = W'(MAX);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d  = count_q;
        overflow = 1'b0;
        if (inc && !dec) begin
            if (count_q == MaxCount) begin
                overflow = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= MaxCount;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/flit_tx.sv
// Credit-based flit transmitter: fetches flits from a registered source queue and sends
// one flit per three cycles, tracking packet framing and downstream credits.
module flit_tx
    import flit_tx_pkg::*;
#(
    parameter int unsigned CREDITS = 8,
    parameter int unsigned FLIT_W  = DATA_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              q_empty,
    input  logic [FLIT_W-1:0] q_data,
    output logic              q_read,
    output logic              q_en,
    output logic              tx_valid,
    output logic [FLIT_W-1:0] tx_flit,
    input  logic              credit_in,
    output logic [3:0]        credits,
    output logic [15:0]       flit_cnt,
    output logic              pkt_err,
    output logic              credit_err
);

    state_e     state_q, state_d;
    logic       start;
    logic       reserve;
    logic       overflow;
    logic       in_pkt_q;
    logic       frame_bad;
    flit_type_e ftype;

    assign start   = tx_en && !q_empty && (credits != 4'd0);
    assign reserve = (state_d == StRead);

    // Type lives in the top two bits of the flit.
    assign ftype     = flit_type_e'(q_data[FLIT_W-1 -: 2]);
    assign frame_bad = opens_pkt(ftype) ? in_pkt_q : !in_pkt_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRead;
            StRead:  state_d = StLoad;
            StLoad:  state_d = StSend;
            StSend:  state_d = start ? StRead : StIdle;
            default: state_d = StIdle;
        endcase
    end

    credit_counter #(
        .MAX (CREDITS),
        .W   (4)
    ) u_credit_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (credit_in),
        .dec      (reserve),
        .count    (credits),
        .overflow (overflow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            q_read     <= 1'b0;
            tx_valid   <= 1'b0;
            tx_flit    <= '0;
            flit_cnt   <= '0;
            in_pkt_q   <= 1'b0;
            pkt_err    <= 1'b0;
            credit_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_read   <= reserve;
            tx_valid <= (state_d == StSend);
            if (state_q == StLoad) begin
                tx_flit  <= q_data;
                flit_cnt <= flit_cnt + 16'd1;
                if (ftype == FlitHead) begin
                    in_pkt_q <= 1'b1;
                end else if (ftype == FlitTail) begin
                    in_pkt_q <= 1'b0;
                end
                if (frame_bad) begin
                    pkt_err <= 1'b1;
                end
            end
            if (overflow) begin
                credit_err <= 1'b1;
            end
        end
    end

    assign q_en = q_read;

endmodule
